compressor: RTL and testbench



---
 rtl/compressor_if.sv | 30 +++
 rtl/compressor.sv | 132 +++++++++++++
 tb/tb_compressor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/compressor_if.sv
// Stream bundle for the zero-word compressor: upstream beat/handshake in,
// compressed beat/handshake out.
interface compressor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8
);
    localparam int BEAT_W = DATA_WIDTH * NUM_DATA;
    localparam int KEEP_W = BEAT_W / 8;

    logic              wrtEn;
    logic [BEAT_W-1:0] data_in;
    logic              tvalid_in;
    logic              tlast_in;
    logic              tready_in;
    logic [BEAT_W-1:0] data_out;
    logic              tready_out;
    logic              tvalid_out;
    logic              tlast_out;
    logic [KEEP_W-1:0] tkeep;

    modport master (
        output wrtEn, data_in, tvalid_in, tlast_in, tready_in,
        input  data_out, tready_out, tvalid_out, tlast_out, tkeep
    );

    modport slave (
        input  wrtEn, data_in, tvalid_in, tlast_in, tready_in,
        output data_out, tready_out, tvalid_out, tlast_out, tkeep
    );
endinterface

// File: rtl/compressor.sv
// Beat-by-beat zero-word compressor: headers and non-TCP packets pass raw,
// TCP body beats are left-packed behind a word-presence mask byte.
module compressor #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8
) (
    input logic         clk,
    input logic         reset,
    compressor_if.slave bus
);
    localparam int BEAT_W     = DATA_WIDTH * NUM_DATA;
    localparam int KEEP_W     = BEAT_W / 8;
    localparam int CNT_W      = $clog2(NUM_DATA + 1);
    localparam int WORD_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_TCP_BODY,
        ST_PASS_BODY
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] data_out_q, data_out_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;

    logic              tready;
    logic              accept;
    logic              is_tcp_hdr;
    logic [NUM_DATA-1:0] mask;
    logic [CNT_W-1:0]  nz_count;
    logic [CNT_W-1:0]  slot [NUM_DATA];
    logic [BEAT_W-1:0] packed_beat;
    logic [KEEP_W-1:0] packed_keep;

    assign tready = reset && (!tvalid_q || bus.tready_in);
    assign accept = bus.tvalid_in && tready;

    assign is_tcp_hdr = bus.wrtEn
                     && (bus.data_in[111:96] == 16'h0008)
                     && (bus.data_in[191:184] == 8'h06);

    // slot[i] is the packed position word i lands in if it is nonzero
    always_comb begin
        mask     = '0;
        nz_count = '0;
        slot     = '{default: '0};
        for (int i = 0; i < NUM_DATA; i++) begin
            mask[i]  = |bus.data_in[DATA_WIDTH*i +: DATA_WIDTH];
            slot[i]  = nz_count;
            nz_count = nz_count + CNT_W'(mask[i]);
        end
    end

    always_comb begin
        packed_beat = bus.data_in;
        packed_keep = '1;
        if (mask != '1) begin
            packed_beat      = '0;
            packed_beat[7:0] = 8'(mask);
            for (int j = 0; j < NUM_DATA - 1; j++) begin
                for (int i = 0; i < NUM_DATA; i++) begin
                    if (mask[i] && (slot[i] == CNT_W'(j))) begin
                        packed_beat[8 + DATA_WIDTH*j +: DATA_WIDTH] =
                            bus.data_in[DATA_WIDTH*i +: DATA_WIDTH];
                    end
                end
            end
            packed_keep = (KEEP_W'(1) << (1 + int'(nz_count) * WORD_BYTES)) - KEEP_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        tkeep_d    = tkeep_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        if (accept) begin
            tvalid_d   = 1'b1;
            tlast_d    = bus.tlast_in;
            data_out_d = bus.data_in;
            tkeep_d    = '1;
            case (state_q)
                ST_FIRST: begin
                    if (bus.tlast_in)
                        state_d = ST_FIRST;
                    else if (is_tcp_hdr)
                        state_d = ST_TCP_BODY;
                    else
                        state_d = ST_PASS_BODY;
                end
                ST_TCP_BODY: begin
                    data_out_d = packed_beat;
                    tkeep_d    = packed_keep;
                    if (bus.tlast_in)
                        state_d = ST_FIRST;
                end
                ST_PASS_BODY: begin
                    if (bus.tlast_in)
                        state_d = ST_FIRST;
                end
                default: state_d = ST_FIRST;
            endcase
        end else if (bus.tready_in) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FIRST;
            data_out_q <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            tkeep_q    <= tkeep_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.tkeep      = tkeep_q;
    assign bus.tvalid_out = tvalid_q;
    assign bus.tlast_out  = tlast_q;
    assign bus.tready_out = tready;
endmodule

// File: tb/tb_compressor.sv
// Directed bench for the zero-word compressor: header passthrough, TCP body
// compression, raw packets, backpressure and mid-packet reset.
module tb_compressor;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    compressor_if #(.DATA_WIDTH(32), .NUM_DATA(8)) bus ();

    compressor #(.DATA_WIDTH(32), .NUM_DATA(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] make_hdr(input logic [15:0] len, input logic [7:0] proto);
        logic [255:0] v;
        v           = '0;
        v[111:96]   = 16'h0008;
        v[127:120]  = 8'h28;
        v[143:128]  = len;
        v[191:184]  = proto;
        return v;
    endfunction

    // Hand-packed form of make_hdr(len, 8'h06): mask 0x38, then words 3,4,5
    function automatic logic [255:0] make_comp(input logic [15:0] len);
        logic [255:0] v;
        v         = '0;
        v[103:0]  = {32'h06000000, 16'h0000, len, 32'h28000008, 8'h38};
        return v;
    endfunction

    task automatic drive_beat(input logic [255:0] d, input logic last, input logic en);
        @(negedge clk);
        bus.tvalid_in = 1'b1;
        bus.data_in   = d;
        bus.tlast_in  = last;
        bus.wrtEn     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        bus.data_in   = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.wrtEn     = 1'b0;
        bus.data_in   = '0;
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        bus.tready_in = 1'b1;
        #12;
        total++;
        if ({bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !== 290'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.tready_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_tready got=%b want=1", bus.tready_out);
        end
    endtask

    task automatic test_tcp_packet();
        logic [255:0] d [7];
        logic [255:0] e [7];
        logic [31:0]  k [7];
        logic         l [7];
        d[0] = make_hdr(16'hdc05, 8'h06);    e[0] = d[0];                  k[0] = 32'hFFFFFFFF; l[0] = 1'b0;
        d[1] = d[0];                         e[1] = make_comp(16'hdc05);   k[1] = 32'h00001FFF; l[1] = 1'b0;
        d[2] = d[0];                         e[2] = make_comp(16'hdc05);   k[2] = 32'h00001FFF; l[2] = 1'b0;
        d[3] = {8{32'hBA98FEDC}};            e[3] = d[3];                  k[3] = 32'hFFFFFFFF; l[3] = 1'b0;
        d[4] = {8{32'hFEDCBA98}};            e[4] = d[4];                  k[4] = 32'hFFFFFFFF; l[4] = 1'b1;
        d[5] = make_hdr(16'hdc03, 8'h06);    e[5] = d[5];                  k[5] = 32'hFFFFFFFF; l[5] = 1'b0;
        d[6] = d[5];                         e[6] = make_comp(16'hdc03);   k[6] = 32'h00001FFF; l[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_beat(d[i], l[i], 1'b1);
            total++;
            if ({bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !== {e[i], k[i], 1'b1, l[i]}) begin
                bad++;
                $display("[TB] FAIL tcp_beat%0d got=%h want=%h", i,
                         {bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out},
                         {e[i], k[i], 1'b1, l[i]});
            end
        end
        go_idle();
        total++;
        if (bus.tvalid_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tcp_drain_valid got=%b want=0", bus.tvalid_out);
        end
    endtask

    task automatic test_raw_packets();
        logic [255:0] d [5];
        logic         l [5];
        logic         en [5];
        d[0] = make_hdr(16'hdc05, 8'h11); l[0] = 1'b0; en[0] = 1'b1;
        d[1] = make_hdr(16'hdc05, 8'h06); l[1] = 1'b0; en[1] = 1'b1;
        d[2] = '0;                        l[2] = 1'b1; en[2] = 1'b1;
        d[3] = make_hdr(16'hdc05, 8'h06); l[3] = 1'b0; en[3] = 1'b0;
        d[4] = make_hdr(16'hdc05, 8'h06); l[4] = 1'b1; en[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(d[i], l[i], en[i]);
            total++;
            if ({bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !== {d[i], 32'hFFFFFFFF, 1'b1, l[i]}) begin
                bad++;
                $display("[TB] FAIL raw_beat%0d got=%h want=%h", i,
                         {bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out},
                         {d[i], 32'hFFFFFFFF, 1'b1, l[i]});
            end
        end
        go_idle();
    endtask

    task automatic test_zero_beat();
        drive_beat(make_hdr(16'hdc05, 8'h06), 1'b0, 1'b1);
        drive_beat('0, 1'b0, 1'b1);
        total++;
        if ({bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !== {256'd0, 32'h00000001, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL zero_beat got=%h want=%h",
                     {bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out},
                     {256'd0, 32'h00000001, 1'b1, 1'b0});
        end
        drive_beat({224'd0, 32'h0000_0007}, 1'b1, 1'b0);
        total++;
        if ({bus.data_out, bus.tkeep, bus.tlast_out} !== {216'd0, 32'h00000007, 8'h01, 32'h0000001F, 1'b1}) begin
            bad++;
            $display("[TB] FAIL one_word_beat got=%h want=%h",
                     {bus.data_out, bus.tkeep, bus.tlast_out},
                     {216'd0, 32'h00000007, 8'h01, 32'h0000001F, 1'b1});
        end
        go_idle();
    endtask

    task automatic test_back_to_back_backpressure();
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] c;
        a = make_hdr(16'h1234, 8'h11);
        b = {8{32'h11112222}};
        c = {8{32'h33334444}};
        @(negedge clk);
        bus.tready_in = 1'b0;
        drive_beat(a, 1'b0, 1'b0);
        total++;
        if ({bus.data_out, bus.tkeep, bus.tvalid_out} !== {a, 32'hFFFFFFFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL bp_first got=%h want=%h",
                     {bus.data_out, bus.tkeep, bus.tvalid_out}, {a, 32'hFFFFFFFF, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            drive_beat(b, 1'b0, 1'b0);
            total++;
            if ({bus.tready_out, bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !==
                {1'b0, a, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d got=%h want=%h", i,
                         {bus.tready_out, bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out},
                         {1'b0, a, 32'hFFFFFFFF, 1'b1, 1'b0});
            end
        end
        @(negedge clk);
        bus.tready_in = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus.data_out, bus.tvalid_out, bus.tlast_out} !== {b, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL bp_release got=%h want=%h",
                     {bus.data_out, bus.tvalid_out, bus.tlast_out}, {b, 1'b1, 1'b0});
        end
        drive_beat(c, 1'b1, 1'b0);
        total++;
        if ({bus.data_out, bus.tvalid_out, bus.tlast_out} !== {c, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL bp_next got=%h want=%h",
                     {bus.data_out, bus.tvalid_out, bus.tlast_out}, {c, 1'b1, 1'b1});
        end
        go_idle();
        total++;
        if (bus.tvalid_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_drain got=%b want=0", bus.tvalid_out);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [255:0] h;
        h = make_hdr(16'hdc05, 8'h06);
        drive_beat(h, 1'b0, 1'b1);
        @(negedge clk);
        bus.tready_in = 1'b0;
        bus.data_in   = h;
        #2;
        reset         = 1'b0;
        bus.tvalid_in = 1'b0;
        #1;
        total++;
        if ({bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out} !== 290'd0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs got=%h want=0",
                     {bus.data_out, bus.tkeep, bus.tvalid_out, bus.tlast_out});
        end
        @(negedge clk);
        reset         = 1'b1;
        bus.tready_in = 1'b1;
        drive_beat(h, 1'b0, 1'b1);
        total++;
        if ({bus.data_out, bus.tkeep, bus.tvalid_out} !== {h, 32'hFFFFFFFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL midreset_header got=%h want=%h",
                     {bus.data_out, bus.tkeep, bus.tvalid_out}, {h, 32'hFFFFFFFF, 1'b1});
        end
        drive_beat(h, 1'b1, 1'b1);
        total++;
        if ({bus.data_out, bus.tkeep, bus.tlast_out} !== {make_comp(16'hdc05), 32'h00001FFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL midreset_body got=%h want=%h",
                     {bus.data_out, bus.tkeep, bus.tlast_out},
                     {make_comp(16'hdc05), 32'h00001FFF, 1'b1});
        end
        go_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_tcp_packet();
        test_raw_packets();
        test_zero_beat();
        test_back_to_back_backpressure();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
